// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and the
// default operand width.
// Contents: DIV_WIDTH (default operand width), div_state_t (IDLE/RUN/HOLD).
package div_pkg;

   localparam int DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_HOLD
   } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when the subtract does not borrow.
// Ports: r_i/q_i/divisor_i current partial state in, r_o/q_o next partial state out.
// Purely combinational.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   r_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           no_borrow;

   always_comb begin
      // R stays below the divisor, so its top bit is always zero before the shift
      // and the shifted value fits in WIDTH+1 bits.
      shifted   = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
      trial     = shifted - {1'b0, divisor_i};
      // A set R[WIDTH] would mean the shifted value exceeds 2^(WIDTH+1), which can
      // never borrow against a WIDTH-bit divisor; folded in so the step stays exact.
      no_borrow = r_i[WIDTH] | ~trial[WIDTH];
      r_o       = no_borrow ? trial : shifted;
      q_o       = {q_i[WIDTH-2:0], no_borrow};
   end

endmodule : div_step

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider driven from the lab switch/button bus.
// Ports: Clk/Reset_n; LoadA/LoadB capture Din as dividend/divisor in IDLE;
//   Execute (level) starts a run; Quot/Rem result; Busy (RUN), Done (HOLD),
//   DivByZero (sticky in HOLD). Latency: WIDTH RUN cycles, or straight to HOLD on /0.
module shift_sub_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             LoadA,
   input  logic             LoadB,
   input  logic             Execute,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Quot,
   output logic [WIDTH-1:0] Rem,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   step_r;
   logic [WIDTH-1:0] step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_i       (r_q),
      .q_i       (q_q),
      .divisor_i (divisor_q),
      .r_o       (step_r),
      .q_o       (step_q)
   );

   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      r_d        = r_q;
      q_d        = q_q;
      cnt_d      = cnt_q;
      dbz_d      = dbz_q;

      case (state_q)
         DIV_IDLE: begin
            // Execute wins over any load presented in the same cycle.
            if (Execute) begin
               if (divisor_q != '0) begin
                  r_d     = '0;
                  q_d     = dividend_q;
                  cnt_d   = '0;
                  state_d = DIV_RUN;
               end else begin
                  q_d     = '1;
                  r_d     = {1'b0, dividend_q};
                  dbz_d   = 1'b1;
                  state_d = DIV_HOLD;
               end
            end else begin
               if (LoadA) dividend_d = Din;
               if (LoadB) divisor_d  = Din;
            end
         end

         DIV_RUN: begin
            r_d   = step_r;
            q_d   = step_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = DIV_HOLD;
         end

         DIV_HOLD: begin
            // Execute must drop before another run can start.
            if (!Execute) begin
               state_d = DIV_IDLE;
               dbz_d   = 1'b0;
            end
         end

         default: state_d = DIV_IDLE;
      endcase

      Busy      = (state_q == DIV_RUN);
      Done      = (state_q == DIV_HOLD);
      DivByZero = dbz_q;
      Quot      = q_q;
      Rem       = r_q[WIDTH-1:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= DIV_IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         r_q        <= '0;
         q_q        <= '0;
         cnt_q      <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         r_q        <= r_d;
         q_q        <= q_d;
         cnt_q      <= cnt_d;
         dbz_q      <= dbz_d;
      end
   end

endmodule : shift_sub_divider

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: stimulus pushes the arithmetic
// expectation (a/b, a%b, or the divide-by-zero convention) and the edge on which
// Done must rise; an independent monitor pops and compares on each Done rise.
module tb_shift_sub_divider;

   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b0;
   logic         LoadA = 1'b0;
   logic         LoadB = 1'b0;
   logic         Execute = 1'b0;
   logic [W-1:0] Din = '0;
   logic [W-1:0] Quot;
   logic [W-1:0] Rem;
   logic         Busy;
   logic         Done;
   logic         DivByZero;

   shift_sub_divider #(.WIDTH(W)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .LoadA     (LoadA),
      .LoadB     (LoadB),
      .Execute   (Execute),
      .Din       (Din),
      .Quot      (Quot),
      .Rem       (Rem),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [W-1:0] quot;
      logic [W-1:0] rem;
      logic         dbz;
      int           done_edge;
   } exp_t;

   exp_t         sb[$];
   int           edge_cnt = 0;
   int           n_pass = 0;
   int           n_total = 0;
   logic [W-1:0] model_a = '0;
   logic [W-1:0] model_b = '0;
   logic         done_prev = 1'b0;

   always @(posedge Clk) edge_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0d required %0d", name, act, exp);
   endtask

   // Monitor: compare every completed result against the oldest expectation.
   always @(negedge Clk) begin
      exp_t e;
      if (Done && !done_prev) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("quot", 32'(Quot), 32'(e.quot));
            chk("rem", 32'(Rem), 32'(e.rem));
            chk("div_by_zero", 32'(DivByZero), 32'(e.dbz));
            chk("done_edge", 32'(edge_cnt), 32'(e.done_edge));
         end
      end
      done_prev = Done;
   end

   // Expectation from plain arithmetic on the operands last loaded.
   task automatic push_exp();
      exp_t e;
      if (model_b == 0) begin
         e.quot      = '1;
         e.rem       = model_a;
         e.dbz       = 1'b1;
         e.done_edge = edge_cnt + 1;
      end else begin
         e.quot      = model_a / model_b;
         e.rem       = model_a % model_b;
         e.dbz       = 1'b0;
         e.done_edge = edge_cnt + 1 + W;
      end
      sb.push_back(e);
   endtask

   // Ends on a negedge with both load strobes low.
   task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge Clk);
      LoadA = 1'b1; Din = a;
      @(negedge Clk);
      LoadA = 1'b0; LoadB = 1'b1; Din = b;
      @(negedge Clk);
      LoadB = 1'b0;
      model_a = a;
      model_b = b;
   endtask

   task automatic fire();
      Execute = 1'b1;
      push_exp();
   endtask

   task automatic wait_done(input int exp_busy);
      int busy = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge Clk);
         if (Done) seen = 1'b1;
         else if (Busy) busy++;
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (exp_busy >= 0) chk("busy_cycles", 32'(busy), 32'(exp_busy));
   endtask

   task automatic release_exec();
      Execute = 1'b0;
      @(negedge Clk);
      chk("idle_done_low", 32'(Done), 32'd0);
      chk("idle_dbz_clear", 32'(DivByZero), 32'd0);
      chk("idle_busy_low", 32'(Busy), 32'd0);
   endtask

   task automatic full_div(input logic [W-1:0] a, input logic [W-1:0] b);
      load_ops(a, b);
      fire();
      wait_done((b == 0) ? 0 : W);
      release_exec();
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      bit           stable;

      // Reset state
      #1;
      chk("rst_quot", 32'(Quot), 32'd0);
      chk("rst_rem", 32'(Rem), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_dbz", 32'(DivByZero), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Directed cases, including divide by zero and divisor > dividend
      full_div(8'd100, 8'd7);
      full_div(8'd255, 8'd1);
      full_div(8'd5, 8'd9);
      full_div(8'd42, 8'd0);
      full_div(8'd0, 8'd13);
      full_div(8'd255, 8'd255);

      // Both strobes together load Din into both operands
      @(negedge Clk);
      LoadA = 1'b1; LoadB = 1'b1; Din = 8'd12;
      @(negedge Clk);
      LoadA = 1'b0; LoadB = 1'b0;
      model_a = 8'd12; model_b = 8'd12;
      fire();
      wait_done(W);

      // Execute held high after Done: no re-run, outputs frozen
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (!Done || Busy || Quot !== 8'd1 || Rem !== 8'd0) stable = 1'b0;
      end
      chk("hold_stable", 32'(stable), 32'd1);
      // Drop and raise again without reloading: same division repeated
      Execute = 1'b0;
      @(negedge Clk);
      chk("rearm_idle", 32'(Done), 32'd0);
      fire();
      wait_done(W);
      release_exec();

      // LoadA during RUN is ignored
      load_ops(8'd100, 8'd7);
      fire();
      repeat (3) @(negedge Clk);
      LoadA = 1'b1; Din = 8'd3;
      @(negedge Clk);
      LoadA = 1'b0;
      wait_done(-1);
      release_exec();

      // LoadA together with Execute in IDLE: load ignored, operands unchanged
      Din = 8'd3; LoadA = 1'b1;
      fire();
      @(negedge Clk);
      LoadA = 1'b0;
      wait_done(W - 1);
      release_exec();

      // Randomized operands, divisor zero now and then
      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         full_div(ra, rb);
      end

      // Asynchronous reset mid-RUN after four steps
      load_ops(8'd100, 8'd7);
      fire();
      repeat (5) @(negedge Clk);
      chk("busy_before_reset", 32'(Busy), 32'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      void'(sb.pop_back());
      chk("arst_quot", 32'(Quot), 32'd0);
      chk("arst_rem", 32'(Rem), 32'd0);
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_done", 32'(Done), 32'd0);
      chk("arst_dbz", 32'(DivByZero), 32'd0);
      Execute = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      full_div(8'd100, 8'd7);

      repeat (3) @(negedge Clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_shift_sub_divider
